// File: rtl/rect_draw_engine.sv
// Rectangle scan engine: walks a WxH box at (x0,y0) in raster order and emits
// one pixel per clock (x_out, y_out, colour_out, plot) for a 160x120 VGA plot port.
// Latency: pixel k is on the outputs during the (k+1)-th cycle after the accepting edge.
// Backpressure: none; go is only sampled in IDLE. go during DRAW or DONE is dropped, not queued.
//
// Ports:
//   clk, reset           : clock, asynchronous active-high reset
//   go                   : start request, sampled in IDLE only
//   x_in, y_in           : top-left origin
//   width, height        : rectangle size in pixels (0 = empty, completes with no plots)
//   mode                 : 00 fill, 01 outline, 10 erase (bg colour), 11 fill
//   colour_in, bg_colour : draw colour / erase colour
//   x_out, y_out         : registered pixel coordinate (holds outside DRAW)
//   colour_out           : registered pixel colour (holds outside DRAW)
//   plot                 : registered write enable, 0 for clipped/interior/idle cycles
//   busy                 : high in every DRAW cycle
//   done                 : single-cycle completion pulse
module rect_draw_engine #(
   parameter int X_W      = 8,
   parameter int Y_W      = 7,
   parameter int SIZE_W   = 5,
   parameter int SCREEN_W = 160,
   parameter int SCREEN_H = 120,
   parameter int COLOUR_W = 3
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                go,
   input  logic [X_W-1:0]      x_in,
   input  logic [Y_W-1:0]      y_in,
   input  logic [SIZE_W-1:0]   width,
   input  logic [SIZE_W-1:0]   height,
   input  logic [1:0]          mode,
   input  logic [COLOUR_W-1:0] colour_in,
   input  logic [COLOUR_W-1:0] bg_colour,
   output logic [X_W-1:0]      x_out,
   output logic [Y_W-1:0]      y_out,
   output logic [COLOUR_W-1:0] colour_out,
   output logic                plot,
   output logic                busy,
   output logic                done
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_DRAW = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [1:0] MODE_OUTLINE = 2'b01;
   localparam logic [1:0] MODE_ERASE   = 2'b10;

   // Screen limits at one bit wider than the coordinates so a carry out of
   // x0+cx / y0+cy lands above the limit and is clipped rather than wrapping.
   localparam logic [X_W:0] X_LIMIT = (X_W+1)'(SCREEN_W);
   localparam logic [Y_W:0] Y_LIMIT = (Y_W+1)'(SCREEN_H);

   localparam logic [SIZE_W-1:0] SIZE_ONE = SIZE_W'(1);

   // State and latched request
   state_t                state_q, state_d;
   logic [X_W-1:0]        x0_q, x0_d;
   logic [Y_W-1:0]        y0_q, y0_d;
   logic [SIZE_W-1:0]     w_q, w_d;
   logic [SIZE_W-1:0]     h_q, h_d;
   logic [1:0]            mode_q, mode_d;
   logic [COLOUR_W-1:0]   col_q, col_d;
   logic [COLOUR_W-1:0]   bg_q, bg_d;

   // Scan position of the pixel currently on the outputs
   logic [SIZE_W-1:0]     cx_q, cx_d;
   logic [SIZE_W-1:0]     cy_q, cy_d;

   // Registered pixel outputs
   logic [X_W-1:0]        x_out_q, x_out_d;
   logic [Y_W-1:0]        y_out_q, y_out_d;
   logic [COLOUR_W-1:0]   colour_out_q, colour_out_d;
   logic                  plot_q, plot_d;

   // Request decode
   logic                  empty_req;
   logic                  accept;
   logic                  last_pix;
   logic                  emit;

   // Parameters for the pixel being generated this cycle. On the accepting
   // edge they come straight from the inputs so pixel (0,0) is registered at
   // the same edge the request is latched; afterwards from the latched copy.
   logic [X_W-1:0]        src_x0;
   logic [Y_W-1:0]        src_y0;
   logic [SIZE_W-1:0]     src_w;
   logic [SIZE_W-1:0]     src_h;
   logic [1:0]            src_mode;
   logic [COLOUR_W-1:0]   src_col;
   logic [COLOUR_W-1:0]   src_bg;

   // Next pixel position and its rendering
   logic [SIZE_W-1:0]     nxt_cx;
   logic [SIZE_W-1:0]     nxt_cy;
   logic [X_W:0]          sum_x;
   logic [Y_W:0]          sum_y;
   logic                  on_screen;
   logic                  on_border;
   logic                  pix_plot;
   logic [COLOUR_W-1:0]   pix_col;

   assign empty_req = (width == '0) || (height == '0);
   assign accept    = (state_q == S_IDLE) && go && !empty_req;
   assign last_pix  = (cx_q == (w_q - SIZE_ONE)) && (cy_q == (h_q - SIZE_ONE));
   // A new pixel is loaded on the accepting edge and on every DRAW edge
   // except the one that retires the final pixel.
   assign emit      = accept || ((state_q == S_DRAW) && !last_pix);

   assign src_x0   = accept ? x_in      : x0_q;
   assign src_y0   = accept ? y_in      : y0_q;
   assign src_w    = accept ? width     : w_q;
   assign src_h    = accept ? height    : h_q;
   assign src_mode = accept ? mode      : mode_q;
   assign src_col  = accept ? colour_in : col_q;
   assign src_bg   = accept ? bg_colour : bg_q;

   // Raster step: column wraps to 0 and the row advances.
   always_comb begin
      nxt_cx = cx_q;
      nxt_cy = cy_q;
      if (accept) begin
         nxt_cx = '0;
         nxt_cy = '0;
      end else if (cx_q == (w_q - SIZE_ONE)) begin
         nxt_cx = '0;
         nxt_cy = cy_q + SIZE_ONE;
      end else begin
         nxt_cx = cx_q + SIZE_ONE;
      end
   end

   // Pixel rendering for the next scan position.
   always_comb begin
      sum_x     = {1'b0, src_x0} + (X_W+1)'(nxt_cx);
      sum_y     = {1'b0, src_y0} + (Y_W+1)'(nxt_cy);
      on_screen = (sum_x < X_LIMIT) && (sum_y < Y_LIMIT);
      // W=1 or H=1 makes every pixel a border pixel, so outline degenerates
      // to a solid line without special casing.
      on_border = (nxt_cx == '0) || (nxt_cx == (src_w - SIZE_ONE)) ||
                  (nxt_cy == '0) || (nxt_cy == (src_h - SIZE_ONE));
      pix_plot  = on_screen && ((src_mode != MODE_OUTLINE) || on_border);
      pix_col   = (src_mode == MODE_ERASE) ? src_bg : src_col;
   end

   // Next-state, request latch and output register inputs.
   always_comb begin
      state_d      = state_q;
      x0_d         = x0_q;
      y0_d         = y0_q;
      w_d          = w_q;
      h_d          = h_q;
      mode_d       = mode_q;
      col_d        = col_q;
      bg_d         = bg_q;
      cx_d         = cx_q;
      cy_d         = cy_q;
      x_out_d      = x_out_q;
      y_out_d      = y_out_q;
      colour_out_d = colour_out_q;
      plot_d       = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (go) begin
               if (empty_req) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_DRAW;
                  x0_d    = x_in;
                  y0_d    = y_in;
                  w_d     = width;
                  h_d     = height;
                  mode_d  = mode;
                  col_d   = colour_in;
                  bg_d    = bg_colour;
               end
            end
         end
         S_DRAW: begin
            if (last_pix) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (emit) begin
         cx_d         = nxt_cx;
         cy_d         = nxt_cy;
         x_out_d      = sum_x[X_W-1:0];
         y_out_d      = sum_y[Y_W-1:0];
         colour_out_d = pix_col;
         plot_d       = pix_plot;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         x0_q         <= '0;
         y0_q         <= '0;
         w_q          <= '0;
         h_q          <= '0;
         mode_q       <= '0;
         col_q        <= '0;
         bg_q         <= '0;
         cx_q         <= '0;
         cy_q         <= '0;
         x_out_q      <= '0;
         y_out_q      <= '0;
         colour_out_q <= '0;
         plot_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         x0_q         <= x0_d;
         y0_q         <= y0_d;
         w_q          <= w_d;
         h_q          <= h_d;
         mode_q       <= mode_d;
         col_q        <= col_d;
         bg_q         <= bg_d;
         cx_q         <= cx_d;
         cy_q         <= cy_d;
         x_out_q      <= x_out_d;
         y_out_q      <= y_out_d;
         colour_out_q <= colour_out_d;
         plot_q       <= plot_d;
      end
   end

   assign x_out      = x_out_q;
   assign y_out      = y_out_q;
   assign colour_out = colour_out_q;
   assign plot       = plot_q;
   assign busy       = (state_q == S_DRAW);
   assign done       = (state_q == S_DONE);

endmodule

// File: tb/tb_rect_draw_engine.sv
// Self-checking bench for rect_draw_engine: directed scenarios plus random draws,
// each compared cycle by cycle against a pixel-list reference model.
// Inputs are driven on the falling edge; outputs are sampled 1 time unit after the rising edge.
module tb_rect_draw_engine;

   localparam int X_W      = 8;
   localparam int Y_W      = 7;
   localparam int SIZE_W   = 5;
   localparam int SCREEN_W = 160;
   localparam int SCREEN_H = 120;
   localparam int COLOUR_W = 3;

   logic                clk = 1'b0;
   logic                reset;
   logic                go;
   logic [X_W-1:0]      x_in;
   logic [Y_W-1:0]      y_in;
   logic [SIZE_W-1:0]   width;
   logic [SIZE_W-1:0]   height;
   logic [1:0]          mode;
   logic [COLOUR_W-1:0] colour_in;
   logic [COLOUR_W-1:0] bg_colour;
   logic [X_W-1:0]      x_out;
   logic [Y_W-1:0]      y_out;
   logic [COLOUR_W-1:0] colour_out;
   logic                plot;
   logic                busy;
   logic                done;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   rect_draw_engine #(
      .X_W(X_W), .Y_W(Y_W), .SIZE_W(SIZE_W),
      .SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H), .COLOUR_W(COLOUR_W)
   ) dut (
      .clk(clk), .reset(reset), .go(go),
      .x_in(x_in), .y_in(y_in), .width(width), .height(height),
      .mode(mode), .colour_in(colour_in), .bg_colour(bg_colour),
      .x_out(x_out), .y_out(y_out), .colour_out(colour_out),
      .plot(plot), .busy(busy), .done(done)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
      end
   endtask

   // Reference: the k-th pixel of a raster scan, rendered from the drawing rules.
   function automatic void model(input int x0, input int y0, input int w, input int h,
                                 input int md, input int col, input int bg, input int k,
                                 output int ex, output int ey, output int ec, output int ep);
      int cx, cy, sx, sy;
      bit visible, border;
      cx      = k % w;
      cy      = k / w;
      sx      = x0 + cx;
      sy      = y0 + cy;
      visible = (sx < SCREEN_W) && (sy < SCREEN_H);
      border  = (cx == 0) || (cx == w - 1) || (cy == 0) || (cy == h - 1);
      ex      = sx % 256;
      ey      = sy % 128;
      ec      = (md == 2) ? bg : col;
      ep      = (visible && (md != 1 || border)) ? 1 : 0;
   endfunction

   // Issue one request and check every cycle through DONE and the following IDLE.
   // inj >= 0 pulses go for one cycle after pixel inj; hold keeps go high afterwards.
   task automatic run_draw(input int x0, input int y0, input int w, input int h,
                           input int md, input int col, input int bg,
                           input int inj, input bit hold, output int nplot);
      int ex, ey, ec, ep, last_x, last_y;
      nplot  = 0;
      last_x = 0;
      last_y = 0;
      @(negedge clk);
      x_in      = X_W'(x0);
      y_in      = Y_W'(y0);
      width     = SIZE_W'(w);
      height    = SIZE_W'(h);
      mode      = 2'(md);
      colour_in = COLOUR_W'(col);
      bg_colour = COLOUR_W'(bg);
      go        = 1'b1;
      @(posedge clk); #1;
      if (!hold) go = 1'b0;
      // The draw in progress must ignore these.
      x_in      = X_W'($urandom);
      y_in      = Y_W'($urandom);
      width     = SIZE_W'($urandom_range(1, 31));
      height    = SIZE_W'($urandom_range(1, 31));
      mode      = 2'($urandom);
      colour_in = COLOUR_W'($urandom);
      bg_colour = COLOUR_W'($urandom);
      for (int k = 0; k < w * h; k++) begin
         model(x0, y0, w, h, md, col, bg, k, ex, ey, ec, ep);
         chk("busy_draw", 32'(busy), 1);
         chk("done_draw", 32'(done), 0);
         chk("plot", 32'(plot), ep);
         chk("x_out", 32'(x_out), ex);
         chk("y_out", 32'(y_out), ey);
         chk("colour_out", 32'(colour_out), ec);
         if (plot) nplot++;
         last_x = ex;
         last_y = ey;
         if (k == inj) go = 1'b1;
         @(posedge clk); #1;
         if (k == inj) go = 1'b0;
      end
      chk("done_pulse", 32'(done), 1);
      chk("busy_done", 32'(busy), 0);
      chk("plot_done", 32'(plot), 0);
      if (w * h > 0) begin
         chk("x_hold", 32'(x_out), last_x);
         chk("y_hold", 32'(y_out), last_y);
      end
      @(posedge clk); #1;
      chk("done_idle", 32'(done), 0);
      chk("busy_idle", 32'(busy), 0);
      chk("plot_idle", 32'(plot), 0);
   endtask

   initial begin
      int n, rx, ry, rw, rh, rm;

      // Reset held with a go request pending.
      reset     = 1'b1;
      go        = 1'b1;
      x_in      = 8'd10;
      y_in      = 7'd20;
      width     = 5'd4;
      height    = 5'd4;
      mode      = 2'b00;
      colour_in = 3'b100;
      bg_colour = 3'b000;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_x", 32'(x_out), 0);
      chk("rst_y", 32'(y_out), 0);
      chk("rst_colour", 32'(colour_out), 0);
      chk("rst_plot", 32'(plot), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      reset = 1'b0;

      // 4x4 fill at (10,20)
      run_draw(10, 20, 4, 4, 0, 4, 0, -1, 1'b0, n);
      chk("fill4x4_plots", 32'(n), 16);

      // Outline 5x3: only the three interior pixels are suppressed
      run_draw(0, 0, 5, 3, 1, 2, 0, -1, 1'b0, n);
      chk("outline5x3_plots", 32'(n), 12);

      // Clipping at the bottom-right corner and across the x carry
      run_draw(158, 118, 4, 4, 0, 6, 0, -1, 1'b0, n);
      chk("clip_corner_plots", 32'(n), 4);
      run_draw(254, 0, 4, 1, 0, 6, 0, -1, 1'b0, n);
      chk("clip_wrap_plots", 32'(n), 0);

      // Empty request: done the cycle after go, no busy, no plot
      run_draw(5, 5, 0, 7, 0, 7, 0, -1, 1'b0, n);
      chk("empty_plots", 32'(n), 0);

      // Reset during the 6th pixel of an 8x8 fill
      @(negedge clk);
      x_in      = 8'd30;
      y_in      = 7'd40;
      width     = 5'd8;
      height    = 5'd8;
      mode      = 2'b00;
      colour_in = 3'b101;
      go        = 1'b1;
      @(posedge clk); #1;
      go = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      chk("pix5_x", 32'(x_out), 35);
      chk("pix5_busy", 32'(busy), 1);
      reset = 1'b1;
      #1;
      chk("arst_x", 32'(x_out), 0);
      chk("arst_y", 32'(y_out), 0);
      chk("arst_colour", 32'(colour_out), 0);
      chk("arst_plot", 32'(plot), 0);
      chk("arst_busy", 32'(busy), 0);
      chk("arst_done", 32'(done), 0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("arst_hold_done", 32'(done), 0);
      end
      reset = 1'b0;
      run_draw(30, 40, 8, 8, 0, 5, 0, -1, 1'b0, n);
      chk("after_rst_plots", 32'(n), 64);

      // Erase 2x2 with a stray go pulse mid-draw
      run_draw(50, 60, 2, 2, 2, 7, 0, 1, 1'b0, n);
      chk("erase_plots", 32'(n), 4);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("no_second_done", 32'(done), 0);
         chk("no_second_busy", 32'(busy), 0);
      end

      // go held through DONE: back-to-back draws with one idle cycle between
      run_draw(100, 10, 3, 2, 3, 1, 0, -1, 1'b1, n);
      run_draw(20, 100, 2, 3, 0, 3, 0, -1, 1'b0, n);
      chk("b2b_plots", 32'(n), 6);

      // Random draws, biased towards the screen edges
      for (int t = 0; t < 24; t++) begin
         rx = ($urandom_range(0, 1) == 1) ? $urandom_range(150, 255) : $urandom_range(0, 255);
         ry = ($urandom_range(0, 1) == 1) ? $urandom_range(112, 127) : $urandom_range(0, 127);
         rw = $urandom_range(0, 7);
         rh = $urandom_range(0, 7);
         rm = $urandom_range(0, 3);
         run_draw(rx, ry, rw, rh, rm, $urandom_range(0, 7), $urandom_range(0, 7), -1, 1'b0, n);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/rect_draw_engine.md
Name: rect_draw_engine

Overview:
- Parametrised successor to the fixed 4x4 square plotter. Scans a WxH rectangle at a given origin and emits one pixel per clock (x, y, colour, plot) straight into the 160x120 VGA adapter's plot port.
- Supports run-time width and height, and three modes: fill, outline and erase.
- Clips pixels that fall off-screen.
- Uses a go/busy/done handshake so a sequencer (e.g. note/lane renderer) can chain draws.

Parameters:
- X_W, 8, x coordinate width
- Y_W, 7, y coordinate width
- SIZE_W, 5, width/height field width; max rectangle 31x31
- SCREEN_W, 160, visible columns; x >= SCREEN_W is clipped
- SCREEN_H, 120, visible rows; y >= SCREEN_H is clipped
- COLOUR_W, 3, colour width

Ports:
- clk  in  1  system clock (CLOCK_50 domain)
- reset  in  1  asynchronous, active-high reset
- go  in  1  start request; sampled only in IDLE
- x_in  in  X_W  origin x (top-left)
- y_in  in  Y_W  origin y (top-left)
- width  in  SIZE_W  pixel columns; 0 = empty
- height  in  SIZE_W  pixel rows; 0 = empty
- mode  in  2  00 fill, 01 outline, 10 erase, 11 treated as fill
- colour_in  in  COLOUR_W  draw colour
- bg_colour  in  COLOUR_W  colour used by erase
- x_out  out  X_W  pixel x (registered)
- y_out  out  Y_W  pixel y (registered)
- colour_out  out  COLOUR_W  pixel colour (registered)
- plot  out  1  write-enable to VGA adapter (registered)
- busy  out  1  high while scanning
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset (async, any state):
  - State goes to IDLE.
  - x_out, y_out, colour_out, plot, busy, done all 0.
  - Internal counters cleared.
  - An in-progress draw is abandoned; no done pulse.
- States and transitions:
  - IDLE -> DRAW on go=1, unless width or height is 0.
  - IDLE -> DONE on go=1 when width=0 or height=0; no plot is ever asserted for that request.
  - DRAW -> DONE after pixel (W-1, H-1) has been emitted.
  - DONE -> IDLE unconditionally after one cycle.
- Latching: on the accepting edge, x_in, y_in, width, height, mode, colour_in and bg_colour are latched. Input changes afterwards do not affect the current draw.
- Scan order: raster, row-major. Column counter cx runs 0..W-1; row counter cy runs 0..H-1; cx wraps to 0 and cy increments.
- Throughput and latency: one pixel per cycle. Pixel k (k = cy*W + cx) is presented on the outputs k+1 cycles after the accepting go edge.
- busy: high in every DRAW cycle. A W*H draw gives exactly W*H busy cycles.
- done: high for the single DONE cycle; busy is 0 in that cycle.
- Pixel outputs:
  - x_out = x0 + cx, truncated to X_W bits.
  - y_out = y0 + cy, truncated to Y_W bits.
- Clipping: the sums are formed at X_W+1 and Y_W+1 bits. plot=0 for a pixel when sum_x >= SCREEN_W or sum_y >= SCREEN_H; this includes carry-out wrap past 255/127. The scan still spends the cycle on that pixel.
- Mode behaviour:
  - Fill: plot=1 for every unclipped pixel; colour_out = colour_in.
  - Outline: plot=1 only where cx==0, cx==W-1, cy==0 or cy==H-1; interior cycles have plot=0. W=1 or H=1 degenerates to a full line.
  - Erase: behaves as fill with colour_out = bg_colour.
- go while busy or done: ignored, not queued. A go held high through DONE is accepted in the following IDLE cycle, giving back-to-back draws with one idle cycle between them.
- Outside DRAW: plot=0. x_out, y_out and colour_out hold their last values.

Test Plan:
- Reset with go=1, x_in=10, y_in=20, width=4, height=4, mode=00, colour_in=3'b100 -> 16 consecutive plot=1 cycles starting 1 cycle after go, covering x 10..13 and y 20..23 in raster order, colour 100; then done=1 for exactly 1 cycle.
- Outline 5x3 at (0,0) -> 15 busy cycles; plot=1 on 12 of them; plot=0 only at (1,1), (2,1), (3,1).
- Clip: origin (158,118), size 4x4 -> 16 busy cycles, plot=1 only for (158,118), (159,118), (158,119), (159,119). Also origin (254,0), width 4, height 1 -> no plot, because the wrap is caught by the carry bit.
- Width=0, height=7, go -> busy never rises, plot never rises, done pulses the cycle after go.
- Assert reset on the 6th pixel of an 8x8 fill -> all outputs 0 immediately (asynchronously); no done; a new go after reset release starts from pixel (0,0).
- Erase mode with colour_in=3'b111, bg_colour=3'b000, size 2x2 -> 4 plots, all with colour_out 000. A go pulse injected mid-draw is ignored and produces no second done.
